// File: rtl/simd_alu_result_stage.sv
// simd_alu_result_stage
//
// Result stage that sits behind the SIMD adder. Each accepted vector has its
// per-byte overflow/underflow flags collapsed to per-lane flags (lane size
// chosen by in_mode). Those lane flags are re-expanded onto every byte of the
// lane. Flagged lanes are optionally saturated. The result goes into a
// 2-entry FIFO toward the consumer. Sticky status bits and a saturating event
// counter record what has been accepted, so software can read it back.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready depends on stored state only)
//   in_data            raw lane results (DATA_WIDTH bits)
//   in_ovf/in_udf      per-byte overflow/underflow flags
//   in_mode            lane size: 0=8b, 1=16b, 2=32b, 3=64b
//   in_signed          lanes are two's complement
//   in_sat_en          replace flagged lanes with saturated values
//   out_valid/ready    downstream handshake for the FIFO head
//   out_data           head result
//   out_ovf/out_udf    head lane flags, replicated per byte
//   clr_status         clear sticky flags and counter (the clear wins over nothing;
//                      a push in the same cycle is counted after the clear)
//   sticky_ovf/udf     any lane overflow/underflow accepted since last clear
//   sat_cnt            accepted vectors with at least one saturated lane
module simd_alu_result_stage #(
  parameter int DATA_WIDTH = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_ovf,
  input  logic [DATA_WIDTH/8-1:0] in_udf,
  input  logic [1:0]              in_mode,
  input  logic                    in_signed,
  input  logic                    in_sat_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_ovf,
  output logic [DATA_WIDTH/8-1:0] out_udf,
  input  logic                    clr_status,
  output logic                    sticky_ovf,
  output logic                    sticky_udf,
  output logic [CNT_WIDTH-1:0]    sat_cnt
);

  localparam int NB = DATA_WIDTH / 8;

  // Lane flags and lane-MSB masks are precomputed for all four lane sizes.
  // in_mode then selects one of them, which keeps the decode a simple mux.
  logic [NB-1:0] ovf_by_mode [4];
  logic [NB-1:0] udf_by_mode [4];
  logic [NB-1:0] msb_by_mode [4];

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int LB = 1 << m;
    for (genvar l = 0; l < NB / LB; l++) begin : g_lane
      assign ovf_by_mode[m][l*LB +: LB] = {LB{|in_ovf[l*LB +: LB]}};
      assign udf_by_mode[m][l*LB +: LB] = {LB{|in_udf[l*LB +: LB]}};
      assign msb_by_mode[m][l*LB +: LB] = LB'(1) << (LB - 1);
    end
  end

  logic [NB-1:0]         lane_ovf;
  logic [NB-1:0]         lane_udf;
  logic [NB-1:0]         lane_msb;
  logic [DATA_WIDTH-1:0] sat_data;
  logic                  sat_event;

  // Overflow wins when a lane carries both flags.
  assign lane_ovf  = ovf_by_mode[in_mode];
  assign lane_udf  = udf_by_mode[in_mode] & ~lane_ovf;
  assign lane_msb  = msb_by_mode[in_mode];
  assign sat_event = in_sat_en && (|(lane_ovf | lane_udf));

  // Signed lanes saturate to max/min two's complement. Only the lane's top
  // byte differs from the unsigned pattern (0x7F / 0x80 instead of 0xFF / 0x00).
  always_comb begin
    sat_data = in_data;
    if (in_sat_en) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_ovf[b]) begin
          sat_data[b*8 +: 8] = (in_signed && lane_msb[b]) ? 8'h7F : 8'hFF;
        end else if (lane_udf[b]) begin
          sat_data[b*8 +: 8] = (in_signed && lane_msb[b]) ? 8'h80 : 8'h00;
        end
      end
    end
  end

  // Two-entry FIFO storage with one-bit read/write pointers.
  logic [DATA_WIDTH-1:0] mem_data [2];
  logic [NB-1:0]         mem_ovf  [2];
  logic [NB-1:0]         mem_udf  [2];
  logic [1:0]            count;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  push;
  logic                  pop;

  // Ready depends only on the stored count, so out_ready has no path to
  // in_ready. A full FIFO refuses a push even when it pops in the same cycle.
  assign in_ready  = !rst && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_data[rd_ptr];
  assign out_ovf   = mem_ovf[rd_ptr];
  assign out_udf   = mem_udf[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_ovf[i]  <= '0;
        mem_udf[i]  <= '0;
      end
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= sat_data;
        mem_ovf[wr_ptr]  <= lane_ovf;
        mem_udf[wr_ptr]  <= lane_udf;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The clear is applied before the current push's event. So a push in the
  // clearing cycle leaves only its own contribution in the status.
  logic [CNT_WIDTH-1:0] cnt_base;
  logic [CNT_WIDTH-1:0] cnt_next;

  always_comb begin
    cnt_base = clr_status ? '0 : sat_cnt;
    cnt_next = cnt_base;
    if (push && sat_event && (cnt_base != {CNT_WIDTH{1'b1}})) begin
      cnt_next = cnt_base + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_udf <= 1'b0;
      sat_cnt    <= '0;
    end else begin
      sticky_ovf <= (sticky_ovf && !clr_status) || (push && (|lane_ovf));
      sticky_udf <= (sticky_udf && !clr_status) || (push && (|lane_udf));
      sat_cnt    <= cnt_next;
    end
  end

endmodule

// File: tb/tb_simd_alu_result_stage.sv
// tb_simd_alu_result_stage
//
// Directed bench for simd_alu_result_stage. It covers reset state, each lane
// size with saturation, flag precedence, pass-through mode and backpressure
// ordering. It also covers clear-with-push, counter saturation and reset with
// buffered entries. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at that same point.
module tb_simd_alu_result_stage;

  localparam int DW = 256;
  localparam int NB = DW / 8;
  localparam int CW = 16;

  localparam logic [DW-1:0] BASE = {32{8'hA5}};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [NB-1:0] in_ovf;
  logic [NB-1:0] in_udf;
  logic [1:0]    in_mode;
  logic          in_signed;
  logic          in_sat_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_ovf;
  logic [NB-1:0] out_udf;
  logic          clr_status;
  logic          sticky_ovf;
  logic          sticky_udf;
  logic [CW-1:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  simd_alu_result_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ovf     (in_ovf),
    .in_udf     (in_udf),
    .in_mode    (in_mode),
    .in_signed  (in_signed),
    .in_sat_en  (in_sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .out_udf    (out_udf),
    .clr_status (clr_status),
    .sticky_ovf (sticky_ovf),
    .sticky_udf (sticky_udf),
    .sat_cnt    (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one vector, waits (bounded) for in_ready, and completes exactly
  // one accepting edge before dropping in_valid.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic [NB-1:0] ovf,
                               input logic [NB-1:0] udf, input logic [1:0] mode,
                               input logic sgn, input logic sat);
    int guard;
    in_data   = data;
    in_ovf    = ovf;
    in_udf    = udf;
    in_mode   = mode;
    in_signed = sgn;
    in_sat_en = sat;
    in_valid  = 1'b1;
    guard     = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) checkOutput("push_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_ovf     = '0;
    in_udf     = '0;
    in_mode    = 2'd0;
    in_signed  = 1'b0;
    in_sat_en  = 1'b0;
    out_ready  = 1'b1;
    clr_status = 1'b0;

    // Reset state
    tick();
    checkOutput("ready_in_reset", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_sat_cnt", sat_cnt, 0);
    checkOutput("rst_sticky_ovf", sticky_ovf, 0);
    checkOutput("rst_sticky_udf", sticky_udf, 0);

    // Mode 0 unsigned saturate on byte 0
    applyStimulus({{31{8'hA5}}, 8'h04}, 32'h1, 32'h0, 2'd0, 1'b0, 1'b1);
    checkOutput("m0_valid", out_valid, 1);
    checkOutput("m0_data", out_data, {{31{8'hA5}}, 8'hFF});
    checkOutput("m0_ovf", out_ovf, 32'h0000_0001);
    checkOutput("m0_udf", out_udf, 32'h0);
    checkOutput("m0_sat_cnt", sat_cnt, 1);
    checkOutput("m0_sticky_ovf", sticky_ovf, 1);
    checkOutput("m0_sticky_udf", sticky_udf, 0);

    // Mode 1 signed: underflow, overflow, then both flags set
    applyStimulus(BASE, 32'h0, 32'h2, 2'd1, 1'b1, 1'b1);
    checkOutput("m1_udf_data", out_data, {{30{8'hA5}}, 16'h8000});
    checkOutput("m1_udf_flags", out_udf, 32'h3);
    checkOutput("m1_udf_sticky", sticky_udf, 1);
    applyStimulus(BASE, 32'h2, 32'h0, 2'd1, 1'b1, 1'b1);
    checkOutput("m1_ovf_data", out_data, {{30{8'hA5}}, 16'h7FFF});
    checkOutput("m1_ovf_flags", out_ovf, 32'h3);
    applyStimulus(BASE, 32'h2, 32'h2, 2'd1, 1'b1, 1'b1);
    checkOutput("m1_both_data", out_data, {{30{8'hA5}}, 16'h7FFF});
    checkOutput("m1_both_udf", out_udf, 32'h0);
    checkOutput("m1_both_ovf", out_ovf, 32'h3);
    checkOutput("m1_sat_cnt", sat_cnt, 4);

    // Mode 3 pass-through: flags reported, data and counter untouched
    applyStimulus({{24{8'hA5}}, 64'h0123_4567_89AB_CDEF}, 32'h80, 32'h0, 2'd3, 1'b0, 1'b0);
    checkOutput("m3_data", out_data, {{24{8'hA5}}, 64'h0123_4567_89AB_CDEF});
    checkOutput("m3_ovf", out_ovf, 32'h0000_00FF);
    checkOutput("m3_sticky_ovf", sticky_ovf, 1);
    checkOutput("m3_sat_cnt", sat_cnt, 4);

    // Mode 2 signed underflow on the top lane
    applyStimulus(BASE, 32'h0, 32'h8000_0000, 2'd2, 1'b1, 1'b1);
    checkOutput("m2_data", out_data, {32'h8000_0000, {28{8'hA5}}});
    checkOutput("m2_udf", out_udf, 32'hF000_0000);
    checkOutput("m2_sat_cnt", sat_cnt, 5);

    // Clear together with a saturating push
    clr_status = 1'b1;
    applyStimulus(BASE, 32'h1, 32'h0, 2'd0, 1'b0, 1'b1);
    clr_status = 1'b0;
    checkOutput("clr_sat_cnt", sat_cnt, 1);
    checkOutput("clr_sticky_ovf", sticky_ovf, 1);
    checkOutput("clr_sticky_udf", sticky_udf, 0);
    tick();
    checkOutput("drain_empty", out_valid, 0);

    // Backpressure: A and B fill the FIFO, C waits upstream
    out_ready = 1'b0;
    applyStimulus({32{8'h11}}, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    applyStimulus({32{8'h22}}, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("full_in_ready", in_ready, 0);
    in_data  = {32{8'h33}};
    in_valid = 1'b1;
    tick();
    tick();
    checkOutput("full_hold_ready", in_ready, 0);
    checkOutput("head_A", out_data, {32{8'h11}});
    out_ready = 1'b1;
    tick();
    checkOutput("head_B", out_data, {32{8'h22}});
    checkOutput("one_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    checkOutput("head_C", out_data, {32{8'h33}});
    checkOutput("pushpop_valid", out_valid, 1);
    checkOutput("pushpop_ready", in_ready, 1);
    tick();
    checkOutput("bp_drained", out_valid, 0);

    // Reset with two buffered entries
    out_ready = 1'b0;
    applyStimulus({32{8'h44}}, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    applyStimulus({32{8'h55}}, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_ready", in_ready, 1);
    checkOutput("midrst_sat_cnt", sat_cnt, 0);

    // Counter saturation: one saturating push per cycle
    out_ready = 1'b1;
    in_data   = BASE;
    in_ovf    = 32'h1;
    in_udf    = 32'h0;
    in_mode   = 2'd0;
    in_signed = 1'b0;
    in_sat_en = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      tick();
      if (i == (1 << CW) - 3) checkOutput("cnt_fffe", sat_cnt, 16'hFFFE);
    end
    in_valid = 1'b0;
    checkOutput("cnt_saturated", sat_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_alu_result_stage.md
Name: simd_alu_result_stage

Overview:
- Downstream consumer of the SIMD adder results: takes the 256-bit result vector plus per-byte overflow/underflow flags.
- Optionally saturates each lane according to lane width and signedness.
- Buffers results in a 2-entry valid/ready FIFO toward the writeback/consumer.
- Keeps sticky status and a saturation event counter for software readout.

Parameters:
- DATA_WIDTH, 256, vector width in bits; must be a multiple of 64.
- CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept a result this cycle.
- in_data  in  DATA_WIDTH  raw lane results from the adder.
- in_ovf  in  DATA_WIDTH/8  per-byte overflow flags.
- in_udf  in  DATA_WIDTH/8  per-byte underflow flags.
- in_mode  in  2  lane size: 0=8b, 1=16b, 2=32b, 3=64b.
- in_signed  in  1  1 = signed lanes.
- in_sat_en  in  1  1 = saturate flagged lanes; 0 = pass wrapped result through.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_WIDTH  head result.
- out_ovf  out  DATA_WIDTH/8  head per-byte lane overflow (lane-expanded).
- out_udf  out  DATA_WIDTH/8  head per-byte lane underflow (lane-expanded).
- clr_status  in  1  clear sticky flags and counter.
- sticky_ovf  out  1  any lane overflow accepted since last clear.
- sticky_udf  out  1  any lane underflow accepted since last clear.
- sat_cnt  out  CNT_WIDTH  vectors accepted with at least one saturated lane.

Behaviour:
- Reset (rst=1 at clock edge):
  - FIFO count=0, both entries cleared.
  - out_valid=0; out_data/out_ovf/out_udf=0.
  - sticky_ovf=sticky_udf=0; sat_cnt=0.
  - in_ready=0 during the reset cycle, 1 on the first cycle after.
  - Reset mid-transfer discards buffered entries.
- Accept: push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count<2). It is registered-state only, with no combinational path from out_ready.
  - When full, no push occurs even if a pop happens that cycle.
  - Push and pop in the same cycle at count=1 leaves count=1 with the new entry at the head.
- Latency: a result accepted at edge N appears on out_* after edge N (out_valid=1 the following cycle) when the FIFO was empty. Order is strict FIFO.
- Empty: out_valid=0; out_data holds its last value (don't-care). Full: count=2, in_ready=0.
- Lane flag derivation, for lane width L=8<<in_mode bytes/8:
  - lane_ovf = OR of in_ovf over the lane's bytes; lane_udf likewise from in_udf.
  - If both are set, overflow takes precedence and lane_udf is treated as 0.
  - out_ovf/out_udf store the lane flag replicated on every byte of the lane.
- Saturation, applied only if in_sat_en=1, per lane:
  - lane_ovf, unsigned: all ones.
  - lane_ovf, signed: 0 followed by all ones (max positive).
  - lane_udf, unsigned: all zeros.
  - lane_udf, signed: 1 followed by all zeros (min negative).
  - Unflagged lanes and in_sat_en=0 pass in_data unchanged. Flags are still reported.
- Status updates happen only on push:
  - sticky_ovf |= any lane_ovf; sticky_udf |= any lane_udf.
  - sat_cnt increments if in_sat_en && any flagged lane.
  - sat_cnt saturates at all ones (no wrap).
- clr_status in the same cycle as a push: clear is applied first, then the event. Result: sticky reflects only the new vector; sat_cnt=0 or 1.
- Unknown in_mode is not possible (2 bits fully decoded). Mode/signed/sat_en are sampled only on push.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, sat_cnt=0, sticky_*=0.
- Mode 0, unsigned, sat_en=1, in_data byte0=0x04, in_ovf[0]=1, other flags 0 -> next cycle out_data byte0=0xFF, other bytes unchanged, out_ovf=0x00000001, sat_cnt=1, sticky_ovf=1.
- Mode 1, signed, sat_en=1, in_udf[1]=1 (MS byte of lane 0) -> out_data[15:0]=0x8000, out_udf[1:0]=2'b11. Same with in_ovf[1]=1 instead -> out_data[15:0]=0x7FFF. Both flags set -> 0x7FFF, out_udf[1:0]=0.
- Mode 3, sat_en=0, in_ovf[7]=1, in_data[63:0]=0x0123456789ABCDEF -> out_data unchanged, out_ovf[7:0]=0xFF, sticky_ovf=1, sat_cnt unchanged.
- Backpressure: out_ready=0, push A, B -> in_ready=0 after 2 pushes; C is held by upstream. Raise out_ready -> A, B, C delivered in order, no loss or duplication. Push and pop at count=1 keeps count=1.
- clr_status asserted together with a saturating push while sat_cnt=5 -> sat_cnt=1. Drive 2^CNT_WIDTH+3 saturating pushes -> sat_cnt=0xFFFF. rst asserted with 2 entries buffered -> out_valid=0 next cycle.
